// File: rtl/fetch_queue_stage.sv
// Fetch stage with a DEPTH-entry prefetch queue. Issues sequential word
// addresses on a valid/ready request channel, collects in-order responses
// into the queue, and presents {instruction, address} pairs downstream.
// A jump flushes the queue, redirects the PC and drops in-flight responses.
module fetch_queue_stage #(
    parameter int                ADDR_W     = 30,
    parameter int                INST_W     = 32,
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_in,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_valid,
    input  logic [INST_W-1:0] resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_addr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              r_init;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_outst;
    logic [CW-1:0]     r_discard;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [INST_W-1:0] r_q_inst [DEPTH];
    logic [ADDR_W-1:0] r_q_addr [DEPTH];

    logic              w_jump;
    logic              w_req_fire;
    logic              w_out_fire;
    logic              w_resp_take;
    logic              w_push;
    logic              w_pop;
    logic [CW:0]       w_credit;

    // Credit uses registered counters only, so outstanding+count never exceeds DEPTH.
    assign w_credit    = {1'b0, r_outst} + {1'b0, r_count};
    assign req_valid   = clk_en & r_init & ~rst & ~jmp & (w_credit < (CW+1)'(DEPTH));
    assign req_addr    = r_pc;
    assign out_valid   = clk_en & (r_count != '0);
    assign out_inst    = r_q_inst[r_rptr];
    assign out_addr    = r_q_addr[r_rptr];

    assign w_jump      = jmp & clk_en & ~rst;
    assign w_req_fire  = req_valid & req_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_resp_take = resp_valid & clk_en;
    // A response is kept only on the normal path and when nothing is pending discard.
    assign w_push      = w_resp_take & ~rst & ~w_jump & (r_discard == '0);
    // A pop coinciding with a jump or reset is swallowed by the flush.
    assign w_pop       = w_out_fire & ~rst & ~w_jump;

    // Queue storage: write the pushed response at the tail.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_wptr] <= resp_data;
            r_q_addr[r_wptr] <= r_resp_pc;
        end
    end

    // Control state: PC, response PC, queue pointers and credit/discard counters.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                r_init    <= 1'b0;
                r_pc      <= RESET_ADDR;
                r_resp_pc <= RESET_ADDR;
                r_count   <= '0;
                r_outst   <= '0;
                r_discard <= '0;
                r_wptr    <= '0;
                r_rptr    <= '0;
            end else begin
                r_init <= 1'b1;
                if (jmp) begin
                    // Every unanswered request becomes a response to drop.
                    r_pc      <= jmp_in;
                    r_resp_pc <= jmp_in;
                    r_count   <= '0;
                    r_wptr    <= '0;
                    r_rptr    <= '0;
                    r_outst   <= r_outst - CW'(w_resp_take);
                    r_discard <= r_outst - CW'(w_resp_take);
                end else begin
                    if (w_req_fire)
                        r_pc <= r_pc + ADDR_W'(1);
                    r_outst <= r_outst + CW'(w_req_fire) - CW'(w_resp_take);
                    if (w_resp_take) begin
                        if (r_discard != '0)
                            r_discard <= r_discard - CW'(1);
                        else
                            r_resp_pc <= r_resp_pc + ADDR_W'(1);
                    end
                    if (w_push)
                        r_wptr <= r_wptr + PW'(1);
                    if (w_pop)
                        r_rptr <= r_rptr + PW'(1);
                    r_count <= r_count + CW'(w_push) - CW'(w_pop);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed phases followed by random traffic,
// checked against a transaction-level model (expected request address,
// queue contents as an address list, in-flight and to-drop counts). A second
// narrow instance checks address wrap.
module tb_fetch_queue_stage;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst, clk_en, jmp;
    logic [29:0] jmp_in;
    logic        req_valid, req_ready;
    logic [29:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_valid, out_ready;
    logic [31:0] out_inst;
    logic [29:0] out_addr;

    logic        req_valid2, resp_valid2, out_valid2;
    logic [3:0]  req_addr2, out_addr2;
    logic [31:0] resp_data2, out_inst2;

    fetch_queue_stage #(.ADDR_W(30), .INST_W(32), .DEPTH(DEPTH), .RESET_ADDR(30'd0)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .jmp(jmp), .jmp_in(jmp_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr)
    );

    fetch_queue_stage #(.ADDR_W(4), .INST_W(32), .DEPTH(4), .RESET_ADDR(4'd14)) dut_w (
        .clk(clk), .rst(rst), .clk_en(1'b1), .jmp(1'b0), .jmp_in(4'd0),
        .req_valid(req_valid2), .req_ready(1'b1), .req_addr(req_addr2),
        .resp_valid(resp_valid2), .resp_data(resp_data2),
        .out_valid(out_valid2), .out_ready(1'b1), .out_inst(out_inst2), .out_addr(out_addr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] a;
        int          due;
    } mreq_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    // reference model
    mreq_t       mem[$];
    logic [29:0] m_q[$];
    logic [29:0] m_pc;
    bit          m_init;
    int          m_inflight, m_discard;
    // wrap-instance model
    logic [3:0]  e2_req, e2_out, pend_a2;
    bit          pend2;
    int          n_pop, n_pop2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] f(input logic [29:0] a);
        return ({a, 2'b10} * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] f2(input logic [3:0] a);
        return {28'hA5A5_C3C, a};
    endfunction

    initial begin
        bit          exp_rv, exp_ov, rf, of, take;
        int          lat, rprob;
        mreq_t       e;

        rst = 1'b1; clk_en = 1'b1; jmp = 1'b0; jmp_in = '0;
        req_ready = 1'b0; out_ready = 1'b0;
        resp_valid = 1'b0; resp_data = '0;
        resp_valid2 = 1'b0; resp_data2 = '0;
        // first edge resets both instances
        m_pc = '0; m_init = 0; m_inflight = 0; m_discard = 0;
        e2_req = 4'd14; e2_out = 4'd14; pend2 = 0; pend_a2 = '0;
        n_pop = 0; n_pop2 = 0;

        for (cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            // ---- stimulus by phase ----
            rst = 1'b0; clk_en = 1'b1; jmp = 1'b0; jmp_in = $urandom;
            req_ready = 1'b1; out_ready = 1'b1; lat = 2; rprob = 100;
            if (cyc < 2) rst = 1'b1;
            else if (cyc >= 80 && cyc < 100) out_ready = 1'b0;
            else if (cyc == 125) begin jmp = 1'b1; jmp_in = 30'h100; end
            else if (cyc >= 145 && cyc < 150) clk_en = 1'b0;
            else if (cyc >= 160) begin
                clk_en    = ($urandom_range(0, 99) < 90);
                rst       = ($urandom_range(0, 199) == 0);
                jmp       = ($urandom_range(0, 99) < 5);
                if ($urandom_range(0, 3) == 0) jmp_in = 30'h3FFF_FFFE;
                req_ready = ($urandom_range(0, 99) < 70);
                out_ready = ($urandom_range(0, 99) < 70);
                lat       = $urandom_range(1, 4);
                rprob     = 80;
            end
            resp_valid = !rst && mem.size() > 0 && mem[0].due <= cyc &&
                         ($urandom_range(0, 99) < rprob);
            resp_data  = resp_valid ? f(mem[0].a) : $urandom;
            resp_valid2 = pend2 && !rst;
            resp_data2  = resp_valid2 ? f2(pend_a2) : $urandom;
            #1;
            // ---- checks: main instance ----
            exp_rv = clk_en && m_init && !rst && !jmp && (m_inflight + m_q.size() < DEPTH);
            exp_ov = clk_en && (m_q.size() > 0);
            chk("req_valid", 64'(req_valid), 64'(exp_rv));
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            if (exp_rv) chk("req_addr", 64'(req_addr), 64'(m_pc));
            if (exp_ov) begin
                chk("out_addr", 64'(out_addr), 64'(m_q[0]));
                chk("out_inst", 64'(out_inst), 64'(f(m_q[0])));
            end
            // ---- checks: wrap instance ----
            if (!rst) begin
                if (req_valid2) chk("w_req_addr", 64'(req_addr2), 64'(e2_req));
                if (out_valid2) begin
                    chk("w_out_addr", 64'(out_addr2), 64'(e2_out));
                    chk("w_out_inst", 64'(out_inst2), 64'(f2(e2_out)));
                end
            end
            // ---- model update for the coming edge ----
            rf = exp_rv && req_ready;
            of = exp_ov && out_ready;
            take = resp_valid && clk_en;
            if (clk_en) begin
                if (rst) begin
                    mem.delete(); m_q.delete();
                    m_pc = '0; m_init = 0; m_inflight = 0; m_discard = 0;
                end else begin
                    m_init = 1;
                    if (jmp) begin
                        if (take) begin void'(mem.pop_front()); m_inflight--; end
                        m_discard = m_inflight;
                        m_q.delete();
                        m_pc = jmp_in;
                    end else begin
                        if (of) begin void'(m_q.pop_front()); n_pop++; end
                        if (take) begin
                            e = mem.pop_front();
                            m_inflight--;
                            if (m_discard > 0) m_discard--;
                            else m_q.push_back(e.a);
                        end
                        if (rf) begin
                            mem.push_back('{a: m_pc, due: cyc + lat});
                            m_pc = m_pc + 30'd1;
                            m_inflight++;
                        end
                    end
                end
            end
            if (rst) begin
                e2_req = 4'd14; e2_out = 4'd14; pend2 = 0;
            end else begin
                pend2   = req_valid2;
                pend_a2 = req_addr2;
                if (req_valid2) e2_req = e2_req + 4'd1;
                if (out_valid2) begin e2_out = e2_out + 4'd1; n_pop2++; end
            end
        end
        chk("main_pops", 64'(n_pop >= 100), 64'd1);
        chk("wrap_pops", 64'(n_pop2 >= 4), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
